periph_bus_rr_arbiter: RTL and testbench
========================================

// Module: periph_bus_rr_arbiter
// PURPOSE
//  N-master to 1-slave arbiter for peripheral-interconnect request/response buses, parametrised in
//  data/address width and master count. Round-robin grant with a request held stable while stalled.
//  Masters' index is driven out as the slave-side request ID; responses are routed back by r_id.
//  Per-master outstanding-transaction limit, optional registered response stage, sticky error on stray responses.
// PARAMETERS
//  N_MASTERS        4   number of master ports (>=2)
//  ADDR_WIDTH       32  address width
//  DATA_WIDTH       32  data width (multiple of 8); BE_WIDTH = DATA_WIDTH/8
//  MAX_OUTSTANDING  4   max granted-but-unanswered transactions per master (>=1)
//  REG_RSP          0   0: response path combinational; 1: response registered, +1 cycle latency
//  ID_WIDTH         derived = max(1,$clog2(N_MASTERS))
// PORTS
//  clk_i         in   1                        clock
//  rst_i         in   1                        asynchronous reset, active-high
//  m_req_i       in   N_MASTERS                per-master request
//  m_add_i       in   N_MASTERS x ADDR_WIDTH   per-master address
//  m_wen_i       in   N_MASTERS                1 = read, 0 = write
//  m_wdata_i     in   N_MASTERS x DATA_WIDTH   write data
//  m_be_i        in   N_MASTERS x BE_WIDTH     byte enables
//  m_gnt_o       out  N_MASTERS                per-master grant
//  m_r_valid_o   out  N_MASTERS                per-master response valid
//  m_r_rdata_o   out  N_MASTERS x DATA_WIDTH   response data (broadcast, qualify with r_valid)
//  m_r_opc_o     out  N_MASTERS                response error opcode (broadcast)
//  s_req_o       out  1                        slave request
//  s_add_o / s_wen_o / s_wdata_o / s_be_o  out  ADDR/1/DATA/BE  muxed request fields
//  s_id_o        out  ID_WIDTH                 index of selected master
//  s_gnt_i       in   1                        slave grant
//  s_r_valid_i   in   1                        slave response valid
//  s_r_id_i      in   ID_WIDTH                 response destination ID
//  s_r_rdata_i   in   DATA_WIDTH               response data
//  s_r_opc_i     in   1                        response opcode
//  err_o         out  1                        sticky: response for master with zero outstanding or ID>=N_MASTERS
// BEHAVIOUR
//  - Reset: rr pointer=0, hold flag=0, outstanding counters=0, err_o=0, response regs (REG_RSP=1)=0.
//    All comb outputs follow inputs; with no requests s_req_o=0, m_gnt_o=0.
//  - Eligible(i) = m_req_i[i] & (cnt[i] < MAX_OUTSTANDING). Response in the same cycle does NOT free a slot
//    for that cycle's eligibility (uses registered cnt).
//  - Selection: if hold=1, selected = held index; else first eligible master at or after rr pointer, wrapping.
//    s_req_o = hold | any eligible; request fields/s_id_o muxed from selected master, same cycle (0 latency).
//  - m_gnt_o[sel] = s_gnt_i & s_req_o; all other grants 0.
//  - Handshake (s_req_o & s_gnt_i): rr pointer <= sel+1 (wrap at N_MASTERS-1 -> 0); hold <= 0; cnt[sel]++.
//  - Stall (s_req_o & ~s_gnt_i): hold <= 1, held index latched; selection must not change until handshake.
//    Master must keep req/fields stable while ungranted; arbiter does not check this.
//  - Response: s_r_valid_i with valid ID i and cnt[i]>0 -> cnt[i]--, m_r_valid_o[i]=1 (REG_RSP=0 same cycle,
//    REG_RSP=1 next cycle, data/opc registered alongside). Invalid ID or cnt[i]==0: no routing, no counter change, err_o<=1.
//  - Simultaneous handshake and response on same master: cnt unchanged (net 0).
//  - cnt width = $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING, never underflows.
//  - err_o clears only on reset. Reset mid-transaction drops all outstanding state; late slave responses then set err_o.
//  - Slave returns at most one response per cycle; responses may be out of order across masters.
// TESTING
//  1) N=4, all req=1, s_gnt_i=1 every cycle -> grants cycle 0..7: M0,M1,M2,M3,M0,M1,M2,M3; s_id_o matches.
//  2) M1 and M2 req, s_gnt_i=0 for 3 cycles then 1 -> s_id_o=1 held all 4 cycles, m_gnt_o=0010 on cycle 3 only.
//  3) MAX_OUTSTANDING=2, M0 req only, no responses -> 2 grants then s_req_o=0; one response r_id=0 -> next cycle grant resumes.
//  4) REG_RSP=1, response r_id=3 rdata=0xDEADBEEF opc=0 -> m_r_valid_o=1000, rdata=0xDEADBEEF exactly 1 cycle later; REG_RSP=0 same cycle.
//  5) Response r_id=2 with cnt[2]=0 -> no m_r_valid_o, err_o=1 next cycle and stays 1 until rst_i.
//  6) Assert rst_i asynchronously mid-stall with cnt=3 -> err_o=0, counters 0, hold 0 immediately; first grant after release to M0.

Source files
------------

// File: rtl/periph_bus_rr_arbiter.sv
// periph_bus_rr_arbiter: round-robin N-master to 1-slave request/response arbiter with per-master outstanding limits
module periph_bus_rr_arbiter #(
    parameter int N_MASTERS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REG_RSP         = 0,
    localparam int ID_WIDTH       = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1,
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_MASTERS-1:0]             m_req_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_add_i,
    input  logic [N_MASTERS-1:0]             m_wen_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata_i,
    input  logic [N_MASTERS*BE_WIDTH-1:0]    m_be_i,
    output logic [N_MASTERS-1:0]             m_gnt_o,
    output logic [N_MASTERS-1:0]             m_r_valid_o,
    output logic [N_MASTERS*DATA_WIDTH-1:0]  m_r_rdata_o,
    output logic [N_MASTERS-1:0]             m_r_opc_o,
    output logic                             s_req_o,
    output logic [ADDR_WIDTH-1:0]            s_add_o,
    output logic                             s_wen_o,
    output logic [DATA_WIDTH-1:0]            s_wdata_o,
    output logic [BE_WIDTH-1:0]              s_be_o,
    output logic [ID_WIDTH-1:0]              s_id_o,
    input  logic                             s_gnt_i,
    input  logic                             s_r_valid_i,
    input  logic [ID_WIDTH-1:0]              s_r_id_i,
    input  logic [DATA_WIDTH-1:0]            s_r_rdata_i,
    input  logic                             s_r_opc_i,
    output logic                             err_o
);
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(N_MASTERS - 1);
    localparam logic [ID_WIDTH:0] NM = (ID_WIDTH + 1)'(N_MASTERS);

    logic [ID_WIDTH-1:0] rr_ptr, held, pick, sel;
    logic [ID_WIDTH:0] idx;
    logic hold, found, hs, rsp_err;
    logic [CNT_WIDTH-1:0] cnt [N_MASTERS];
    logic [N_MASTERS-1:0] elig, rsp_hit;

    // Eligibility uses the registered count, so a same-cycle response never frees a slot early
    always_comb begin
        elig = '0;
        rsp_hit = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            elig[i] = m_req_i[i] && (cnt[i] < CNT_MAX);
            rsp_hit[i] = s_r_valid_i && (s_r_id_i == ID_WIDTH'(i)) && (cnt[i] != '0);
        end
        rsp_err = s_r_valid_i && !(|rsp_hit);
    end

    always_comb begin
        found = 1'b0;
        pick = '0;
        idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(k);
            idx = (idx >= NM) ? idx - NM : idx;
            if (!found && elig[idx[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                pick = idx[ID_WIDTH-1:0];
            end
        end
    end

    assign sel       = hold ? held : pick;
    assign s_req_o   = hold | found;
    assign hs        = s_req_o & s_gnt_i;
    assign s_id_o    = sel;
    assign s_add_o   = m_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_wen_o   = m_wen_i[sel];
    assign s_wdata_o = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign s_be_o    = m_be_i[sel*BE_WIDTH +: BE_WIDTH];

    always_comb begin
        m_gnt_o = '0;
        m_gnt_o[sel] = hs;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            hold <= 1'b0;
            held <= '0;
            err_o <= 1'b0;
            for (int i = 0; i < N_MASTERS; i++) cnt[i] <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
                hold <= 1'b0;
            end else if (s_req_o) begin
                hold <= 1'b1;
                held <= sel;
            end
            if (rsp_err) err_o <= 1'b1;
            for (int i = 0; i < N_MASTERS; i++)
                cnt[i] <= cnt[i] + CNT_WIDTH'(hs && (sel == ID_WIDTH'(i))) - CNT_WIDTH'(rsp_hit[i]);
        end
    end

    if (REG_RSP != 0) begin : g_reg_rsp
        logic [N_MASTERS-1:0] vld_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic opc_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= '0;
                data_q <= '0;
                opc_q <= 1'b0;
            end else begin
                vld_q <= rsp_hit;
                data_q <= s_r_rdata_i;
                opc_q <= s_r_opc_i;
            end
        end
        assign m_r_valid_o = vld_q;
        assign m_r_rdata_o = {N_MASTERS{data_q}};
        assign m_r_opc_o   = {N_MASTERS{opc_q}};
    end else begin : g_comb_rsp
        assign m_r_valid_o = rsp_hit;
        assign m_r_rdata_o = {N_MASTERS{s_r_rdata_i}};
        assign m_r_opc_o   = {N_MASTERS{s_r_opc_i}};
    end
endmodule

// File: tb/tb_periph_bus_rr_arbiter.sv
// tb_periph_bus_rr_arbiter: directed checks on a default instance and a MAX_OUTSTANDING=2, REG_RSP=1 instance
module tb_periph_bus_rr_arbiter;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] req_a, wen_a, gnt_a, rv_a, opc_a;
    logic [127:0] add_a, wdata_a, rdata_a;
    logic [15:0] be_a;
    logic sreq_a, swen_a, sgnt_a, rvalid_a, sopc_a, err_a;
    logic [31:0] sadd_a, swdata_a, srdata_a;
    logic [3:0] sbe_a;
    logic [1:0] sid_a, rid_a;

    logic [3:0] req_b, wen_b, gnt_b, rv_b, opc_b;
    logic [127:0] add_b, wdata_b, rdata_b;
    logic [15:0] be_b;
    logic sreq_b, swen_b, sgnt_b, rvalid_b, sopc_b, err_b;
    logic [31:0] sadd_b, swdata_b, srdata_b;
    logic [3:0] sbe_b;
    logic [1:0] sid_b, rid_b;

    periph_bus_rr_arbiter dut_a (
        .clk_i(clk), .rst_i(rst_a), .m_req_i(req_a), .m_add_i(add_a), .m_wen_i(wen_a),
        .m_wdata_i(wdata_a), .m_be_i(be_a), .m_gnt_o(gnt_a), .m_r_valid_o(rv_a),
        .m_r_rdata_o(rdata_a), .m_r_opc_o(opc_a), .s_req_o(sreq_a), .s_add_o(sadd_a),
        .s_wen_o(swen_a), .s_wdata_o(swdata_a), .s_be_o(sbe_a), .s_id_o(sid_a),
        .s_gnt_i(sgnt_a), .s_r_valid_i(rvalid_a), .s_r_id_i(rid_a), .s_r_rdata_i(srdata_a),
        .s_r_opc_i(sopc_a), .err_o(err_a)
    );

    periph_bus_rr_arbiter #(.MAX_OUTSTANDING(2), .REG_RSP(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .m_req_i(req_b), .m_add_i(add_b), .m_wen_i(wen_b),
        .m_wdata_i(wdata_b), .m_be_i(be_b), .m_gnt_o(gnt_b), .m_r_valid_o(rv_b),
        .m_r_rdata_o(rdata_b), .m_r_opc_o(opc_b), .s_req_o(sreq_b), .s_add_o(sadd_b),
        .s_wen_o(swen_b), .s_wdata_o(swdata_b), .s_be_o(sbe_b), .s_id_o(sid_b),
        .s_gnt_i(sgnt_b), .s_r_valid_i(rvalid_b), .s_r_id_i(rid_b), .s_r_rdata_i(srdata_b),
        .s_r_opc_i(sopc_b), .err_o(err_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        req_a = '0; sgnt_a = 0; rvalid_a = 0; rid_a = '0; srdata_a = '0; sopc_a = 0;
        req_b = '0; sgnt_b = 0; rvalid_b = 0; rid_b = '0; srdata_b = '0; sopc_b = 0;
        add_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        wdata_a = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        be_a = 16'h8421;
        wen_a = 4'b0101;
        add_b = add_a; wdata_b = wdata_a; be_b = be_a; wen_b = wen_a;
        repeat (2) @(negedge clk);
        rst_a = 0; rst_b = 0;
        #1;
        check("rst_sreq", sreq_a, 0);
        check("rst_gnt", gnt_a, 0);
        check("rst_err", err_a, 0);
        check("rst_rv_b", rv_b, 0);

        // round robin with continuous grant
        @(negedge clk);
        req_a = 4'hF; sgnt_a = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t1_id", sid_a, c % 4);
            check("t1_gnt", gnt_a, 1 << (c % 4));
            check("t1_add", sadd_a, 32'hA0 + c % 4);
            check("t1_wdata", swdata_a, 32'hD0 + c % 4);
            check("t1_be", sbe_a, 1 << (c % 4));
            check("t1_wen", swen_a, wen_a[c % 4]);
            @(negedge clk);
        end

        // stall holds M1 even when M0 starts requesting
        req_a = 4'b0110; sgnt_a = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req_a = 4'b0111;
            if (c == 3) sgnt_a = 1;
            #1;
            check("t2_req", sreq_a, 1);
            check("t2_id", sid_a, 1);
            check("t2_gnt", gnt_a, (c == 3) ? 4'b0010 : 4'b0000);
            @(negedge clk);
        end
        #1;
        check("t2_next_id", sid_a, 2);
        @(negedge clk);
        req_a = '0; sgnt_a = 0;

        // combinational response routing, cnt now 2,3,3,2
        rvalid_a = 1; rid_a = 3; srdata_a = 32'hDEADBEEF; sopc_a = 0;
        #1;
        check("t4_rv_comb", rv_a, 4'b1000);
        check("t4_rdata_comb", rdata_a[127:96], 32'hDEADBEEF);
        check("t4_opc_comb", opc_a, 0);
        @(negedge clk);
        rid_a = 2;
        for (int c = 0; c < 3; c++) begin
            sopc_a = (c == 1);
            #1;
            check("t5_drain_rv", rv_a, 4'b0100);
            check("t5_drain_opc", opc_a, (c == 1) ? 4'hF : 4'h0);
            @(negedge clk);
        end
        sopc_a = 0;
        #1;
        check("t5_stray_rv", rv_a, 0);
        check("t5_err_before", err_a, 0);
        @(negedge clk);
        rvalid_a = 0;
        #1;
        check("t5_err_set", err_a, 1);
        repeat (3) @(negedge clk);
        #1;
        check("t5_err_sticky", err_a, 1);

        // async reset mid-stall, cnt[1]=3, ptr=3
        @(negedge clk);
        req_a = 4'b0010; sgnt_a = 0;
        #1;
        check("t6_id", sid_a, 1);
        @(negedge clk);
        req_a = 4'b0011;
        #1;
        check("t6_hold_id", sid_a, 1);
        #2 rst_a = 1;
        #1;
        check("t6_rst_err", err_a, 0);
        check("t6_rst_id", sid_a, 0);
        check("t6_rst_sreq", sreq_a, 1);
        @(negedge clk);
        rst_a = 0; sgnt_a = 1;
        #1;
        check("t6_first_gnt", gnt_a, 4'b0001);
        @(negedge clk);
        req_a = '0; sgnt_a = 0; rvalid_a = 1; rid_a = 1;
        #1;
        check("t6_late_rv", rv_a, 0);
        @(negedge clk);
        rvalid_a = 0;
        #1;
        check("t6_late_err", err_a, 1);

        // outstanding limit of 2 on dut_b
        req_b = 4'b0001; sgnt_b = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t3_gnt", gnt_b, 4'b0001);
            @(negedge clk);
        end
        rvalid_b = 1; rid_b = 0;
        #1;
        check("t3_full_sreq", sreq_b, 0);
        check("t3_full_gnt", gnt_b, 0);
        check("t3_rv_not_yet", rv_b, 0);
        @(negedge clk);
        rvalid_b = 0;
        #1;
        check("t3_rv_reg", rv_b, 4'b0001);
        check("t3_resume_sreq", sreq_b, 1);
        check("t3_resume_gnt", gnt_b, 4'b0001);
        @(negedge clk);
        req_b = 4'b1000;
        #1;
        check("t3_rv_clear", rv_b, 0);
        check("t4_id_b", sid_b, 3);
        check("t4_gnt_b", gnt_b, 4'b1000);

        // registered response one cycle late
        @(negedge clk);
        req_b = '0; sgnt_b = 0;
        rvalid_b = 1; rid_b = 3; srdata_b = 32'hDEADBEEF; sopc_b = 0;
        #1;
        check("t4_rv_early", rv_b, 0);
        @(negedge clk);
        rvalid_b = 0; srdata_b = '0;
        #1;
        check("t4_rv_reg", rv_b, 4'b1000);
        check("t4_rdata_reg", rdata_b[127:96], 32'hDEADBEEF);
        check("t4_opc_reg", opc_b, 0);
        check("t4_err_b", err_b, 0);
        @(negedge clk);
        #1;
        check("t4_rv_pulse", rv_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
